// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues word reads, feeds decode through a 1-entry skid buffer.
// Optional build macro INST_FETCH_ALIGN_CHECK_EN: misaligned redirect raises fetch_exc and halts fetch.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_CODE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_code,
    output logic [31:0] pc_out
`ifdef INST_FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_exc
`endif
);
    // state   | meaning
    // S_REQ   | mem_req high, waiting for mem_ack (possibly a killed read)
    // S_BLOCK | no request: skid full, fetch halted, or first cycle after reset
    typedef enum logic {S_BLOCK = 1'b0, S_REQ = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        kill_q, kill_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_code_q, inst_code_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_code_q, skid_code_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        halt_d;
    logic        ack, word_in, advance, busy;
    logic [31:0] target_pc;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic halt_q, fetch_exc_q, fetch_exc_d, misaligned;
    assign target_pc  = redirect_pc;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign fetch_exc  = fetch_exc_q;
`else
    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign ack     = mem_ack && (state_q == S_REQ);
    assign word_in = ack && !kill_q && !redirect;
    assign advance = inst_valid_q && !stall;
    // a read stays outstanding (address frozen) until its ack, even across redirects
    assign busy    = (state_q == S_REQ) && !mem_ack;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_code_d  = inst_code_q;
        pc_out_d     = pc_out_q;
        skid_valid_d = skid_valid_q;
        skid_code_d  = skid_code_q;
        skid_pc_d    = skid_pc_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        halt_d       = halt_q;
        fetch_exc_d  = fetch_exc_q;
`else
        halt_d       = 1'b0;
`endif
        if (redirect) begin
            inst_valid_d = 1'b0;
            inst_code_d  = NOP_CODE;
            skid_valid_d = 1'b0;
            pc_d         = target_pc;
            kill_d       = busy;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            halt_d       = misaligned;
            fetch_exc_d  = misaligned;
            if (misaligned) begin
                inst_valid_d = 1'b1;
                pc_out_d     = redirect_pc;
            end
`endif
        end else begin
            if (ack)
                kill_d = 1'b0;
            if (word_in)
                pc_d = pc_q + 32'd4;
            if (advance && skid_valid_q) begin
                inst_code_d  = skid_code_q;
                pc_out_d     = skid_pc_q;
                skid_valid_d = word_in;
                skid_code_d  = mem_rdata;
                skid_pc_d    = pc_q;
            end else if (!inst_valid_q || !stall) begin
                inst_valid_d = word_in;
                inst_code_d  = word_in ? mem_rdata : NOP_CODE;
                if (word_in)
                    pc_out_d = pc_q;
            end else if (word_in) begin
                skid_valid_d = 1'b1;
                skid_code_d  = mem_rdata;
                skid_pc_d    = pc_q;
            end
`ifdef INST_FETCH_ALIGN_CHECK_EN
            if (advance)
                fetch_exc_d = 1'b0;
`endif
        end

        if (busy) begin
            state_d = S_REQ;
        end else if (!skid_valid_d && !halt_d) begin
            state_d    = S_REQ;
            mem_addr_d = pc_d;
        end else begin
            state_d = S_BLOCK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BLOCK;
            pc_q         <= RESET_PC;
            mem_addr_q   <= '0;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_code_q  <= NOP_CODE;
            pc_out_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_code_q  <= '0;
            skid_pc_q    <= '0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            halt_q       <= 1'b0;
            fetch_exc_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_code_q  <= inst_code_d;
            pc_out_q     <= pc_out_d;
            skid_valid_q <= skid_valid_d;
            skid_code_q  <= skid_code_d;
            skid_pc_q    <= skid_pc_d;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            halt_q       <= halt_d;
            fetch_exc_q  <= fetch_exc_d;
`endif
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_code  = inst_code_q;
    assign pc_out     = pc_out_q;
endmodule
